exmem_pipe_reg: RTL and testbench
=================================

# exmem_pipe_reg

Parametrised execute-to-memory pipeline register for the RISC-V core, replacing the fixed two-field EX/MEM flop stage. It carries NUM_LANES data words (lane 0 = ALU result, lane 1 = store write data, further lanes are spare) plus a control side-band. Transfers use a valid/ready handshake, so the stage supports stall back-pressure and a synchronous flush (bubble insert). An optional skid slot makes in_ready a registered signal.

## Interface
- DATA_WIDTH, 32, width of each data lane
- NUM_LANES, 2, number of data lanes, minimum 1
- CTRL_WIDTH, 8, width of the control side-band (rd index, write enables, etc.)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush; discards all held and incoming beats
- in_valid  in  1  upstream (EX) beat valid
- in_ready  out  1  stage can accept a beat
- in_data  in  NUM_LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_ctrl  in  CTRL_WIDTH  side-band for the beat
- out_valid  out  1  downstream (MEM) beat valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM_LANES*DATA_WIDTH  registered lanes
- out_ctrl  out  CTRL_WIDTH  registered side-band

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ctrl=0, state EMPTY, skid slot cleared; in_ready=1 in the cycle after reset is released.
- State machine with skid slot enabled:
  - EMPTY: in_fire -> BUSY, with main <= input.
  - BUSY: in_fire & !out_fire -> FULL, with skid <= input. out_fire & !in_fire -> EMPTY. in_fire & out_fire -> BUSY, with main <= input.
  - FULL: out_fire -> BUSY, with main <= skid. in_ready=0, so no input is accepted.
- out_valid = (state != EMPTY). in_ready = (state != FULL), decoded from the state register only.
- flush has priority over everything. Next state is EMPTY and out_valid=0 next cycle. A beat fired in the same cycle is discarded. Data registers hold their values; out_data is don't-care while out_valid=0.
- Beats are never reordered, duplicated or dropped, except by flush.
- Data and ctrl pass unmodified. There is no arithmetic.

## Timing
- Latency is 1 cycle: a beat fired at edge N is on out_data with out_valid=1 after edge N.
- Throughput is 1 beat/cycle while out_ready=1.
- With the skid slot, in_ready has no combinational path from out_ready. Without it, in_ready = !out_valid | out_ready (combinational).
- out_data and out_ctrl change only on out_fire, on a load into an EMPTY stage, or on reset. They are stable while out_valid & !out_ready.
- Reset asserted mid-transfer clears everything immediately, independent of clk.

## Configuration
- EXMEM_SKID_EN defined: the two-entry skid variant with registered in_ready, as above.
- EXMEM_SKID_EN undefined: a single main register with only EMPTY/BUSY states. The FULL state is unreachable and removed. in_ready is combinational per Timing. flush and reset behaviour are unchanged.

## Structure
- Package exmem_pkg:
  - typedef enum logic [1:0] pipe_state_e {EMPTY, BUSY, FULL}
  - default parameter constants
- One natural sub-module: pipe_slot, a load-enabled data+ctrl register with async reset to 0. It is instantiated as main and skid (skid only under EXMEM_SKID_EN).

## Test plan
- Streaming: out_ready=1; drive in_data lanes 0x00000001/0x000000A0, then 0x2/0xA1, then 0x3/0xA2 on consecutive cycles -> each appears on out_data exactly 1 cycle later, out_valid continuous, in_ready=1 throughout.
- Stall: hold out_ready=0 and offer 3 beats -> (skid) 2 beats accepted, in_ready=0 from the cycle after the 2nd accept. On release, outputs are beat 1 then beat 2 in order, then the 3rd beat is accepted. (No-skid) 1 beat accepted.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, state EMPTY, and the incoming beat never appears.
- Simultaneous in_fire & out_fire in BUSY: in_data=0xDEADBEEF, ctrl=0x15 -> next cycle out_data lane 0 = 0xDEADBEEF, out_ctrl=0x15, out_valid stays 1.
- Async reset asserted mid-stall between clock edges -> out_valid=0, out_data=0 immediately. After release, in_ready=1 and the first new beat passes with 1-cycle latency.
- Parameter sweep: NUM_LANES=1/4, DATA_WIDTH=64, both macro settings -> lane 3 value 0x123456789ABCDEF0 passes through intact.

Source files
------------

// File: rtl/exmem_pkg.sv
// Shared types and default sizes for the EX/MEM pipeline register.
package exmem_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_LANES  = 2;
  localparam int DEF_CTRL_WIDTH = 8;
endpackage

// File: rtl/pipe_slot.sv
// Load-enabled storage slot for one beat (lanes + control); clears to 0 on reset.
module pipe_slot #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
  end
endmodule

// File: rtl/exmem_pipe_reg.sv
// EX->MEM valid/ready pipeline register with flush.
// Define EXMEM_SKID_EN for the two-entry variant with a registered in_ready.
module exmem_pipe_reg
  import exmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int CTRL_WIDTH = DEF_CTRL_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0]           in_ctrl,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0]           out_ctrl
);
  localparam int DW = NUM_LANES * DATA_WIDTH;
  localparam int SW = DW + CTRL_WIDTH;

  pipe_state_e   state_q, state_d;
  logic          in_fire, out_fire, main_ld;
  logic [SW-1:0] in_word, main_d, main_q;

  assign in_word   = {in_ctrl, in_data};
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef EXMEM_SKID_EN
  logic          skid_ld, from_skid;
  logic [SW-1:0] skid_q;

  assign in_ready = (state_q != FULL);
  assign main_d   = from_skid ? skid_q : in_word;

  pipe_slot #(.W(SW)) u_skid (
    .clk(clk), .rst_n(rst_n), .ld(skid_ld), .d(in_word), .q(skid_q)
  );
`else
  assign in_ready = !out_valid || out_ready;
  assign main_d   = in_word;
`endif

  pipe_slot #(.W(SW)) u_main (
    .clk(clk), .rst_n(rst_n), .ld(main_ld), .d(main_d), .q(main_q)
  );

  assign out_data = main_q[DW-1:0];
  assign out_ctrl = main_q[SW-1:DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Flush suppresses every load, so held data just goes stale behind out_valid=0.
  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
`ifdef EXMEM_SKID_EN
    skid_ld   = 1'b0;
    from_skid = 1'b0;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d = BUSY;
          main_ld = 1'b1;
        end
        BUSY: begin
          if (in_fire && out_fire) main_ld = 1'b1;
          else if (out_fire)       state_d = EMPTY;
`ifdef EXMEM_SKID_EN
          else if (in_fire) begin
            state_d = FULL;
            skid_ld = 1'b1;
          end
`endif
        end
`ifdef EXMEM_SKID_EN
        FULL: if (out_fire) begin
          state_d   = BUSY;
          main_ld   = 1'b1;
          from_skid = 1'b1;
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Scoreboard bench for exmem_pipe_reg; honours EXMEM_SKID_EN for expectations.
module tb_exmem_pipe_reg;
`ifdef EXMEM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;

  logic         w_in_valid, w_in_ready, w_out_valid;
  logic [255:0] w_in_data, w_out_data;
  logic [7:0]   w_in_ctrl, w_out_ctrl;
  logic         o_in_valid, o_in_ready, o_out_valid;
  logic [63:0]  o_in_data, o_out_data;
  logic [7:0]   o_in_ctrl, o_out_ctrl;

  int tests = 0;
  int fails = 0;
  logic [71:0] sb[$];
  logic [71:0] exp_w;

  exmem_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl)
  );

  exmem_pipe_reg #(.DATA_WIDTH(64), .NUM_LANES(4), .CTRL_WIDTH(8)) u_wide (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data), .in_ctrl(w_in_ctrl),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data), .out_ctrl(w_out_ctrl)
  );

  exmem_pipe_reg #(.DATA_WIDTH(64), .NUM_LANES(1), .CTRL_WIDTH(8)) u_one (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data), .in_ctrl(o_in_ctrl),
    .out_valid(o_out_valid), .out_ready(1'b1), .out_data(o_out_data), .out_ctrl(o_out_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every beat taken downstream must be the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected beat: got %0h expected none", {out_ctrl, out_data});
      end else begin
        exp_w = sb.pop_front();
        chk("out beat", {184'd0, out_ctrl, out_data}, {184'd0, exp_w});
      end
    end
  end

  // One cycle of stimulus; checks handshake outputs mid-cycle and records accepted beats.
  task automatic cyc(input bit v, input logic [63:0] d, input logic [7:0] c, input bit rdy,
                     input bit fl, input bit eov, input bit erdy, input string nm);
    @(posedge clk); #1;
    in_valid = v; in_data = d; in_ctrl = c; out_ready = rdy; flush = fl;
    @(negedge clk);
    chk({nm, " out_valid"}, {255'd0, out_valid}, {255'd0, eov});
    chk({nm, " in_ready"},  {255'd0, in_ready},  {255'd0, erdy});
    if (fl) sb.delete();
    else if (v && erdy) sb.push_back({c, d});
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_data = '0; w_in_ctrl = '0;
    o_in_valid = 1'b0; o_in_data = '0; o_in_ctrl = '0;
    #1;
    chk("reset out_valid", {255'd0, out_valid}, 256'd0);
    chk("reset out_data/ctrl", {184'd0, out_ctrl, out_data}, 256'd0);
    #11 rst_n = 1'b1;
    #1;
    chk("post reset in_ready", {255'd0, in_ready}, 256'd1);

    // Streaming, 1-cycle latency, back-to-back
    cyc(1, 64'h000000A0_00000001, 8'h01, 1, 0, 0, 1, "stream b1");
    cyc(1, 64'h000000A1_00000002, 8'h02, 1, 0, 1, 1, "stream b2");
    cyc(1, 64'h000000A2_00000003, 8'h03, 1, 0, 1, 1, "stream b3");
    cyc(0, 64'h0, 8'h00, 1, 0, 1, 1, "stream drain");

    // Stall with three offered beats
`ifdef EXMEM_SKID_EN
    cyc(1, 64'h000000B1_00000011, 8'h21, 0, 0, 0, 1, "stall b1");
    cyc(1, 64'h000000B2_00000012, 8'h22, 0, 0, 1, 1, "stall b2");
    cyc(1, 64'h000000B3_00000013, 8'h23, 0, 0, 1, 0, "stall b3 full");
    chk("stall hold", {184'd0, out_ctrl, out_data}, {184'd0, 8'h21, 64'h000000B1_00000011});
    cyc(1, 64'h000000B3_00000013, 8'h23, 1, 0, 1, 0, "release b3 blocked");
    cyc(1, 64'h000000B3_00000013, 8'h23, 1, 0, 1, 1, "release b3 accept");
`else
    cyc(1, 64'h000000B1_00000011, 8'h21, 0, 0, 0, 1, "stall b1");
    cyc(1, 64'h000000B2_00000012, 8'h22, 0, 0, 1, 0, "stall b2 blocked");
    cyc(1, 64'h000000B2_00000012, 8'h22, 0, 0, 1, 0, "stall b2 blocked again");
    chk("stall hold", {184'd0, out_ctrl, out_data}, {184'd0, 8'h21, 64'h000000B1_00000011});
    cyc(1, 64'h000000B2_00000012, 8'h22, 1, 0, 1, 1, "release b2 accept");
    cyc(1, 64'h000000B3_00000013, 8'h23, 1, 0, 1, 1, "release b3 accept");
`endif
    cyc(0, 64'h0, 8'h00, 1, 0, 1, 1, "stall drain");

    // Flush with a pending input beat
`ifdef EXMEM_SKID_EN
    cyc(1, 64'h000000C1_00000021, 8'h31, 0, 0, 0, 1, "flush f1");
    cyc(1, 64'h000000C2_00000022, 8'h32, 0, 0, 1, 1, "flush f2");
    cyc(1, 64'h000000C3_00000023, 8'h33, 0, 1, 1, 0, "flush while full");
`else
    cyc(1, 64'h000000C1_00000021, 8'h31, 0, 0, 0, 1, "flush f1");
    cyc(1, 64'h000000C2_00000022, 8'h32, 0, 1, 1, 0, "flush while busy");
`endif
    cyc(0, 64'h0, 8'h00, 1, 0, 0, 1, "post flush empty");
    cyc(1, 64'h000000C4_00000024, 8'h34, 1, 1, 0, 1, "flush drops fired beat");
    cyc(0, 64'h0, 8'h00, 1, 0, 0, 1, "flushed beat absent");

    // Simultaneous in_fire and out_fire in BUSY
    cyc(1, 64'h00000000_11111111, 8'h01, 1, 0, 0, 1, "both g");
    cyc(1, 64'h00000000_DEADBEEF, 8'h15, 1, 0, 1, 1, "both fire");
    cyc(0, 64'h0, 8'h00, 0, 0, 1, SKID, "both hold");
    chk("both lane0", {224'd0, out_data[31:0]}, {224'd0, 32'hDEADBEEF});
    chk("both ctrl", {248'd0, out_ctrl}, {248'd0, 8'h15});
    cyc(0, 64'h0, 8'h00, 1, 0, 1, 1, "both drain");
    cyc(0, 64'h0, 8'h00, 1, 0, 0, 1, "both empty");

    // Asynchronous reset in the middle of a stall
    cyc(1, 64'h000000D1_00000031, 8'h41, 0, 0, 0, 1, "rst h1");
    cyc(1, 64'h000000D2_00000032, 8'h42, 0, 0, 1, SKID, "rst h2");
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {255'd0, out_valid}, 256'd0);
    chk("async rst out_data/ctrl", {184'd0, out_ctrl, out_data}, 256'd0);
    sb.delete();
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    chk("async rst in_ready", {255'd0, in_ready}, 256'd1);
    cyc(1, 64'h000000E1_00000041, 8'h51, 1, 0, 0, 1, "post rst k1");
    cyc(0, 64'h0, 8'h00, 1, 0, 1, 1, "post rst latency");
    cyc(0, 64'h0, 8'h00, 1, 0, 0, 1, "post rst empty");

    // Wide (4x64) and single-lane (1x64) instances
    @(posedge clk); #1;
    w_in_valid = 1'b1; w_in_ctrl = 8'h3C;
    w_in_data  = {64'h123456789ABCDEF0, 64'h0000_0000_0000_000C,
                  64'h0000_0000_0000_000B, 64'h0000_0000_0000_000A};
    o_in_valid = 1'b1; o_in_ctrl = 8'h5A; o_in_data = 64'h123456789ABCDEF0;
    @(negedge clk);
    chk("wide in_ready", {255'd0, w_in_ready}, 256'd1);
    chk("one in_ready", {255'd0, o_in_ready}, 256'd1);
    @(posedge clk); #1;
    w_in_valid = 1'b0; o_in_valid = 1'b0;
    @(negedge clk);
    chk("wide out_valid", {255'd0, w_out_valid}, 256'd1);
    chk("wide lane3", {192'd0, w_out_data[192 +: 64]}, {192'd0, 64'h123456789ABCDEF0});
    chk("wide lane0", {192'd0, w_out_data[0 +: 64]}, {192'd0, 64'h0000_0000_0000_000A});
    chk("wide ctrl", {248'd0, w_out_ctrl}, {248'd0, 8'h3C});
    chk("one out_valid", {255'd0, o_out_valid}, 256'd1);
    chk("one lane0", {192'd0, o_out_data}, {192'd0, 64'h123456789ABCDEF0});
    chk("one ctrl", {248'd0, o_out_ctrl}, {248'd0, 8'h5A});
    @(negedge clk);
    chk("wide drained", {255'd0, w_out_valid}, 256'd0);

    @(negedge clk);
    chk("scoreboard drained", 256'(sb.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
